// File: rtl/arch_defs_pkg.sv
// rtl/arch_defs_pkg.sv - shared architecture widths and stack command encoding
package arch_defs_pkg;

    localparam int ADDR_WIDTH = 16;
    localparam int DATA_WIDTH = 8;

    typedef enum logic [1:0] {
        PUSH8  = 2'd0,
        PUSH16 = 2'd1,
        POP8   = 2'd2,
        POP16  = 2'd3
    } stack_cmd_t;

    function automatic logic cmd_is_pop(stack_cmd_t c);
        return (c == POP8) || (c == POP16);
    endfunction

    function automatic logic cmd_is_wide(stack_cmd_t c);
        return (c == PUSH16) || (c == POP16);
    endfunction

endpackage

// File: rtl/stack_sequencer_if.sv
// rtl/stack_sequencer_if.sv - command handshake between control unit and stack sequencer
interface stack_sequencer_if;
    import arch_defs_pkg::*;

    logic                  cmd_valid;
    logic                  cmd_ready;
    stack_cmd_t            cmd;
    logic [ADDR_WIDTH-1:0] wr_data;
    logic [ADDR_WIDTH-1:0] rd_data;
    logic                  done;
    logic                  error;

    modport master (
        output cmd_valid, cmd, wr_data,
        input  cmd_ready, rd_data, done, error
    );

    modport slave (
        input  cmd_valid, cmd, wr_data,
        output cmd_ready, rd_data, done, error
    );
endinterface

// File: rtl/stack_sequencer.sv
// rtl/stack_sequencer.sv - push/pop microsequencer driving stack pointer strobes and RAM port
module stack_sequencer
    import arch_defs_pkg::*;
#(
    parameter logic [ADDR_WIDTH-1:0] STACK_BASE  = 16'h01FF,
    parameter logic [ADDR_WIDTH-1:0] STACK_LIMIT = 16'h0100
) (
    input  logic                  clk,
    input  logic                  reset,
    stack_sequencer_if.slave      bus,
    input  logic [ADDR_WIDTH-1:0] sp_in,
    output logic                  sp_increment,
    output logic                  sp_decrement,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic                  mem_we,
    output logic                  mem_re,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    typedef enum logic [2:0] {
        IDLE,
        PUSH_WR,
        POP_INC,
        POP_RD,
        POP_CAP,
        DONE
    } state_t;

    state_t                state, state_next;
    stack_cmd_t            cmd_q;
    logic [ADDR_WIDTH-1:0] wdata_q;
    logic [DATA_WIDTH-1:0] low_q;
    logic [ADDR_WIDTH-1:0] rd_data_q;
    logic                  second_q;
    logic                  err_q;
    logic                  violation;
    logic                  last_byte;

    // Bounds check on the incoming command, widened by one bit so nothing wraps
    always_comb begin
        logic [ADDR_WIDTH:0] sp_ext;
        logic [ADDR_WIDTH:0] n_ext;
        sp_ext    = {1'b0, sp_in};
        n_ext     = cmd_is_wide(bus.cmd) ? (ADDR_WIDTH+1)'(2) : (ADDR_WIDTH+1)'(1);
        violation = 1'b0;
        if (cmd_is_pop(bus.cmd)) begin
            violation = (sp_ext + n_ext) > {1'b0, STACK_BASE};
        end else begin
            // sp - (n-1) < limit, rearranged to avoid subtraction
            violation = (sp_ext + (ADDR_WIDTH+1)'(1)) < ({1'b0, STACK_LIMIT} + n_ext);
        end
    end

    // Two-byte commands run their byte loop twice; second_q marks the second pass
    assign last_byte = !cmd_is_wide(cmd_q) || second_q;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic and per-state strobes
    always_comb begin
        state_next    = state;
        bus.cmd_ready = 1'b0;
        bus.done      = 1'b0;
        bus.error     = 1'b0;
        sp_increment  = 1'b0;
        sp_decrement  = 1'b0;
        mem_addr      = '0;
        mem_wdata     = '0;
        mem_we        = 1'b0;
        mem_re        = 1'b0;
        case (state)
            IDLE: begin
                bus.cmd_ready = 1'b1;
                if (bus.cmd_valid) begin
                    if (violation)                state_next = DONE;
                    else if (cmd_is_pop(bus.cmd)) state_next = POP_INC;
                    else                          state_next = PUSH_WR;
                end
            end
            PUSH_WR: begin
                mem_addr     = sp_in;
                mem_we       = 1'b1;
                sp_decrement = 1'b1;
                // PUSH16 sends the high byte first so the low byte lands lower
                mem_wdata    = (cmd_is_wide(cmd_q) && !second_q) ?
                               wdata_q[ADDR_WIDTH-1:DATA_WIDTH] : wdata_q[DATA_WIDTH-1:0];
                state_next   = last_byte ? DONE : PUSH_WR;
            end
            POP_INC: begin
                sp_increment = 1'b1;
                state_next   = POP_RD;
            end
            POP_RD: begin
                mem_addr   = sp_in;
                mem_re     = 1'b1;
                state_next = POP_CAP;
            end
            POP_CAP: begin
                state_next = last_byte ? DONE : POP_INC;
            end
            DONE: begin
                bus.done   = 1'b1;
                bus.error  = err_q;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Command latch, byte-pass tracking and pop result assembly
    always_ff @(posedge clk) begin
        if (reset) begin
            cmd_q     <= PUSH8;
            wdata_q   <= '0;
            low_q     <= '0;
            rd_data_q <= '0;
            second_q  <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.cmd_valid) begin
                        cmd_q    <= bus.cmd;
                        wdata_q  <= bus.wr_data;
                        second_q <= 1'b0;
                        err_q    <= violation;
                    end
                end
                PUSH_WR: second_q <= 1'b1;
                POP_CAP: begin
                    if (!last_byte) begin
                        low_q    <= mem_rdata;
                        second_q <= 1'b1;
                    end else if (cmd_is_wide(cmd_q)) begin
                        rd_data_q <= {mem_rdata, low_q};
                    end else begin
                        rd_data_q <= ADDR_WIDTH'(mem_rdata);
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.rd_data = rd_data_q;

endmodule
